// File: rtl/muldiv_pkg.sv
// muldiv_pkg: constants and types shared by the MULT/DIV sequencer and the
// ALU decoder.
//   ALU_*     4-bit ALU control codes driven by the decoder
//   state_t   sequencer FSM states
//   op_t      operation latched at accept time
//   is_muldiv helper: does this control code belong to the sequencer?
package muldiv_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_NOT  = 4'b1100;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    typedef enum logic {OP_MUL, OP_DIV} op_t;

    function automatic logic is_muldiv(input logic [3:0] code);
        return (code == ALU_MULT) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: per-iteration datapath for unsigned shift-add multiply and
// restoring divide. One iteration per cycle while i_en is high.
//   clk, reset_n  clock, async active-low reset
//   i_load        capture operands and initialise the accumulator
//   i_en          perform one iteration
//   i_op          OP_MUL or OP_DIV (sampled on i_load)
//   i_a, i_b      multiplicand/dividend, multiplier/divisor
//   o_hi, o_lo    upper/lower accumulator halves (product or remainder/quotient)
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_en,
    input  op_t              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    // Multiply: {hi, lo} starts as {0, multiplier}; r_opnd holds the multiplicand.
    // Divide:   {hi, lo} starts as {0, dividend} = {rem, quot}; r_opnd holds the divisor.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    op_t                r_op;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH-1:0]   w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_next;

    // Add the multiplicand into the upper half when the multiplier LSB is set,
    // keeping the carry so the right shift brings it back into the accumulator.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // The shifted remainder needs one extra bit before the trial subtract.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
    assign w_div_next  = w_div_ge ? {w_div_diff,              r_acc[WIDTH-2:0], 1'b1}
                                  : {w_div_shift[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0};

    // NOTE: the accumulator is a handful of flops, not a memory array, so it
    // takes the async reset like every other register here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_opnd <= '0;
            r_op   <= OP_MUL;
        end else if (i_load) begin
            r_op <= i_op;
            if (i_op == OP_MUL) begin
                r_opnd <= i_a;
                r_acc  <= {{WIDTH{1'b0}}, i_b};
            end else begin
                r_opnd <= i_b;
                // Zero divisor: preload the final answer (quot=all ones, rem=dividend).
                r_acc  <= (i_b == '0) ? {i_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, i_a};
            end
        end else if (i_en) begin
            r_acc <= (r_op == OP_MUL) ? w_mul_next : w_div_next;
        end
    end

    assign o_hi = r_acc[2*WIDTH-1:WIDTH];
    assign o_lo = r_acc[WIDTH-1:0];

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle sequencer for ALU MULT/DIV. Accepts an operation
// from decode, stalls the pipeline while the core iterates WIDTH times, then
// commits the result to HI/LO with a one-cycle done pulse.
//   clk, reset_n  clock, async active-low reset
//   alucontrol    ALU control code; only ALU_MULT / ALU_DIV are accepted
//   start         instruction in decode is valid
//   flush         abort the in-flight operation
//   srca, srcb    multiplicand/dividend, multiplier/divisor
//   stall         pipeline hold request (combinational)
//   done          one-cycle pulse when HI/LO are updated
//   div0          sticky: last committed DIV had a zero divisor
//   hi, lo        product upper/lower half, or remainder/quotient
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       alucontrol,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             stall,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    op_t                r_op;
    logic               r_zero_div;
    logic               r_done;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_issue;
    logic               w_accept;
    logic               w_commit;
    op_t                w_op;
    logic [WIDTH-1:0]   w_core_hi;
    logic [WIDTH-1:0]   w_core_lo;

    assign w_issue  = start && is_muldiv(alucontrol);
    // Flush wins over a same-cycle issue.
    assign w_accept = (r_state == IDLE) && w_issue && !flush;
    assign w_commit = (r_state == FIN) && !flush;
    assign w_op     = (alucontrol == ALU_DIV) ? OP_DIV : OP_MUL;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: default assignment first so no path leaves w_next_state unassigned
    // (which would infer a latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: if (w_accept)
                      w_next_state = (w_op == OP_DIV && srcb == '0) ? FIN : RUN;
            RUN:  if (flush)            w_next_state = IDLE;
                  else if (r_cnt == '0) w_next_state = FIN;
            FIN:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // stall covers the issuing cycle itself so the instruction holds in decode.
    always_comb begin
        stall = 1'b0;
        unique case (r_state)
            IDLE:    stall = w_issue && !flush;
            RUN:     stall = 1'b1;
            FIN:     stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // ---------------- counter, operation latch, HI/LO commit ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_op       <= OP_MUL;
            r_zero_div <= 1'b0;
            r_done     <= 1'b0;
            r_div0     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= w_commit;
            if (w_accept) begin
                r_cnt      <= CNT_W'(WIDTH - 1);
                r_op       <= w_op;
                r_zero_div <= (w_op == OP_DIV) && (srcb == '0);
            end else if (r_state == RUN && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_hi <= w_core_hi;
                r_lo <= w_core_lo;
                if (r_op == OP_DIV) r_div0 <= r_zero_div;
            end
        end
    end

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_accept),
        .i_en    (r_state == RUN),
        .i_op    (w_op),
        .i_a     (srca),
        .i_b     (srcb),
        .o_hi    (w_core_hi),
        .o_lo    (w_core_lo)
    );

    assign done = r_done;
    assign div0 = r_div0;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq (WIDTH=32).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (or 1 ns after a falling-edge input change for the combinational stall).
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   alucontrol = ALU_AND;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic         stall;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_compared   = 0;
    int n_mismatched = 0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .alucontrol (alucontrol),
        .start      (start),
        .flush      (flush),
        .srca       (srca),
        .srcb       (srcb),
        .stall      (stall),
        .done       (done),
        .div0       (div0),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    // Present an operation for one cycle through its accepting edge, then
    // scramble the operand inputs so a design that fails to latch them shows it.
    task automatic issue(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic stall_at_issue);
        @(negedge clk);
        alucontrol = ctrl;
        srca       = a;
        srcb       = b;
        start      = 1'b1;
        #1;
        stall_at_issue = stall;
        @(posedge clk);
        #1;
        start      = 1'b0;
        alucontrol = ALU_AND;
        srca       = 32'hA5A5_A5A5;
        srcb       = 32'h5A5A_5A5A;
    endtask

    // Count edges after the accepting edge until done is seen (bounded).
    // If inject_at >= 0, a second DIV start is driven for one cycle at that point.
    task automatic wait_done(input int inject_at, output int edges, output int stalls,
                             output bit seen);
        edges  = 0;
        stalls = 0;
        seen   = 1'b0;
        while (edges < 100) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (stall) stalls++;
            if (edges == inject_at) begin
                start = 1'b1; alucontrol = ALU_DIV; srca = 32'd50; srcb = 32'd5;
            end else if (inject_at >= 0 && edges == inject_at + 1) begin
                start = 1'b0; alucontrol = ALU_AND;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_compared++;
        if ({stall, done, div0} !== 3'b000) begin
            n_mismatched++;
            $display("FAIL reset_flags: stall/done/div0 got %b expected 000", {stall, done, div0});
        end
        n_compared++;
        if ({hi, lo} !== 64'h0) begin
            n_mismatched++;
            $display("FAIL reset_hilo: got %h_%h expected 0_0", hi, lo);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_and_check(input string name, input logic [3:0] ctrl,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int exp_edges, input int exp_stalls,
                                 input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                                 input logic exp_div0, input int inject_at);
        logic s0;
        int   edges, stalls;
        bit   seen;
        issue(ctrl, a, b, s0);
        wait_done(inject_at, edges, stalls, seen);
        n_compared++;
        if (!seen) begin
            n_mismatched++;
            $display("FAIL %s timeout: no done within 100 cycles", name);
        end
        n_compared++;
        if (edges !== exp_edges) begin
            n_mismatched++;
            $display("FAIL %s latency: done after %0d edges expected %0d", name, edges, exp_edges);
        end
        n_compared++;
        if (int'(s0) + stalls !== exp_stalls) begin
            n_mismatched++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, int'(s0) + stalls, exp_stalls);
        end
        n_compared++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_mismatched++;
            $display("FAIL %s result: hi/lo got %h/%h expected %h/%h", name, hi, lo, exp_hi, exp_lo);
        end
        n_compared++;
        if (div0 !== exp_div0) begin
            n_mismatched++;
            $display("FAIL %s div0: got %b expected %b", name, div0, exp_div0);
        end
        @(negedge clk);
        n_compared++;
        if (done !== 1'b0) begin
            n_mismatched++;
            $display("FAIL %s done_pulse: done still %b one cycle later, expected 0", name, done);
        end
    endtask

    task automatic test_mult();
        run_and_check("mult_7x6", ALU_MULT, 32'd7, 32'd6, 33, 33, 32'h0, 32'h2A, 1'b0, -1);
    endtask

    task automatic test_div();
        run_and_check("div_100_7", ALU_DIV, 32'd100, 32'd7, 33, 33, 32'd2, 32'd14, 1'b0, -1);
    endtask

    task automatic test_div_zero();
        // FIN follows accept directly: done one edge after the accepting edge.
        run_and_check("div_by_zero", ALU_DIV, 32'h1234, 32'h0, 1, 1,
                      32'h0000_1234, 32'hFFFF_FFFF, 1'b1, -1);
    endtask

    task automatic test_mult_max();
        // div0 was set by the previous DIV and MULT must leave it alone.
        run_and_check("mult_max", ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 33,
                      32'hFFFF_FFFE, 32'h0000_0001, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        // Second start (DIV 50/5) at RUN cycle 5 must be ignored.
        run_and_check("restart_ignored", ALU_MULT, 32'd9, 32'd11, 33, 33,
                      32'h0, 32'd99, 1'b1, 5);
    endtask

    task automatic test_non_muldiv();
        int bad = 0;
        @(negedge clk);
        alucontrol = ALU_ADD;
        srca = 32'd1;
        srcb = 32'd2;
        start = 1'b1;
        #1;
        n_compared++;
        if (stall !== 1'b0) begin
            n_mismatched++;
            $display("FAIL add_stall: got %b expected 0", stall);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        alucontrol = ALU_AND;
        repeat (5) begin
            @(negedge clk);
            if (done !== 1'b0 || stall !== 1'b0) bad++;
        end
        n_compared++;
        if (bad !== 0) begin
            n_mismatched++;
            $display("FAIL add_ignored: %0d cycles with done/stall set, expected 0", bad);
        end
        n_compared++;
        if (hi !== 32'h0 || lo !== 32'd99) begin
            n_mismatched++;
            $display("FAIL add_hilo: got %h/%h expected 00000000/00000063", hi, lo);
        end
    endtask

    task automatic test_flush();
        logic s0;
        int   dones = 0;
        issue(ALU_MULT, 32'h0001_0000, 32'h0001_0000, s0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_compared++;
        if (stall !== 1'b0) begin
            n_mismatched++;
            $display("FAIL flush_stall: got %b expected 0", stall);
        end
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_compared++;
        if (dones !== 0) begin
            n_mismatched++;
            $display("FAIL flush_done: got %0d done pulses expected 0", dones);
        end
        n_compared++;
        if (hi !== 32'h0 || lo !== 32'd99 || div0 !== 1'b1) begin
            n_mismatched++;
            $display("FAIL flush_keep: hi/lo/div0 got %h/%h/%b expected 00000000/00000063/1",
                     hi, lo, div0);
        end
    endtask

    task automatic test_reset_mid_run();
        logic s0;
        issue(ALU_MULT, 32'hFFFF_FFFF, 32'd3, s0);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_compared++;
        if ({stall, done, div0} !== 3'b000 || {hi, lo} !== 64'h0) begin
            n_mismatched++;
            $display("FAIL midrun_reset: stall/done/div0 %b hi/lo %h/%h expected 000 0/0",
                     {stall, done, div0}, hi, lo);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_and_check("mult_3x5", ALU_MULT, 32'd3, 32'd5, 33, 33, 32'h0, 32'd15, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mult_max();
        test_back_to_back();
        test_non_muldiv();
        test_flush();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the ALU's MULT and DIV operations.
- Accepts an operation when the decoder issues an ALU MULT/DIV control code. Runs an iterative shift-add multiply or restoring divide over WIDTH cycles.
- Holds the pipeline with a stall output while it runs, and writes the result into HI/LO registers.
- Sits beside the single-cycle ALU in the datapath, driven by the ALU control code and the register-file operands.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH): iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- alucontrol  input  4  ALU control code from the ALU decoder; only ALU_MULT and ALU_DIV trigger this block.
- start  input  1  issue strobe; the instruction in decode is valid this cycle.
- flush  input  1  abort the in-flight operation.
- srca  input  WIDTH  multiplicand or dividend.
- srcb  input  WIDTH  multiplier or divisor.
- stall  output  1  pipeline hold request.
- done  output  1  one-cycle pulse when the result is committed.
- div0  output  1  sticky flag; the last DIV had a zero divisor.
- hi  output  WIDTH  product upper half, or remainder.
- lo  output  WIDTH  product lower half, or quotient.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; stall=0, done=0, div0=0, hi=0, lo=0; counter=0; internal accumulators=0.
- States:
  - IDLE. Accept when start=1 and alucontrol is ALU_MULT or ALU_DIV. Latch operands and op. Load counter=WIDTH-1 and go to RUN.
    - Exception: DIV with srcb=0 goes directly to FIN with quotient=all ones, remainder=srca, and div0 set.
    - Any other alucontrol with start=1 is ignored.
  - RUN. One iteration per cycle. Counter decrements. On counter=0, the last iteration completes and the state goes to FIN.
  - FIN. Write HI/LO, pulse done=1, clear stall, return to IDLE.
- Multiply, unsigned: 2*WIDTH accumulator.
  - Each cycle: if multiplier LSB=1, add multiplicand to the upper half; then shift the {carry, acc} right by 1.
  - Result: hi=acc[2W-1:W], lo=acc[W-1:0].
- Divide, unsigned restoring: each cycle, shift {rem, quot} left by 1, then trial-subtract the divisor from rem.
  - If no borrow: keep the difference and set quot LSB=1.
  - Otherwise: restore rem.
  - Result: lo=quotient, hi=remainder.
- div0 is updated only at FIN of a DIV: 1 if the divisor was zero, else 0. MULT leaves it unchanged.
- Latency:
  - Start accepted at edge t; RUN occupies WIDTH cycles; FIN at t+WIDTH+1.
  - done is high, and hi/lo show the new values, in the cycle after edge t+WIDTH+1.
  - Divide-by-zero: FIN directly after accept, so done arrives 2 cycles after start.
- stall is combinational:
  - 1 when state is RUN, or when state is IDLE with start=1 and a MULT/DIV code (so the issuing instruction holds in the same cycle).
  - 0 in FIN.
- hi/lo change only in FIN; intermediate values are internal. Reads of hi/lo during RUN return the previous result.
- start while RUN or FIN: ignored. No queueing; the stall guarantees upstream does not reissue.
- Simultaneous events:
  - flush in RUN or FIN: return to IDLE next edge. No done, hi/lo/div0 unchanged, stall drops.
  - flush in IDLE with start: flush wins and nothing is accepted.
- Reset mid-operation: immediate return to the reset values above; the partial result is discarded.
- All arithmetic is unsigned, modulo 2^(2W) for the accumulator. No overflow flag. Signed MULT/DIV is out of scope.

Decomposition:
- Package muldiv_pkg holds:
  - 4-bit ALU control constants shared with the ALU decoder: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_MULT=1000, ALU_DIV=1001, ALU_SLL=1010, ALU_SRL=1011, ALU_NOT=1100.
  - typedef enum state_t {IDLE, RUN, FIN}.
  - typedef enum op_t {OP_MUL, OP_DIV}.
- Sub-module muldiv_core: the per-iteration datapath (accumulator, shift, add/subtract, restore), stepped by an enable. muldiv_seq keeps the FSM, counter, stall/done and HI/LO.

Test Plan:
- MULT 7 x 6: start with alucontrol=1000 → stall high for 33 cycles; done pulse; hi=0x00000000, lo=0x0000002A.
- MULT 0xFFFFFFFF x 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; div0 unchanged.
- DIV 100 / 7 (alucontrol=1001) → lo=14, hi=2, div0=0; done exactly WIDTH+1 cycles after the accepting edge.
- DIV 0x1234 / 0 → done 2 cycles after start; lo=0xFFFFFFFF, hi=0x00001234, div0=1.
- Second start with different operands during RUN → ignored; result matches the first op. start with alucontrol=0010 in IDLE → no stall, no done.
- flush at RUN cycle 10 → IDLE, no done, hi/lo keep the prior values. Separately, reset_n low at RUN cycle 5 → all outputs 0 immediately; a new MULT 3 x 5 afterwards gives lo=15.
